// File: rtl/pll_pkg.sv
// Shared definitions for the PLL lock sequencer: state encoding and default timing.
package pll_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RUN       = 3'd2,
    ST_FAIL      = 3'd3
  } pll_state_t;

  localparam int DEF_RESET_CYCLES   = 16;
  localparam int DEF_LOCK_STABLE    = 256;
  localparam int DEF_LOCK_TIMEOUT   = 65536;
  localparam int DEF_MAX_RETRIES    = 3;
  localparam int DEF_BYPASS_ON_FAIL = 1;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low clear.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // Two register stages give the first stage a full cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer: pulses RESETB, qualifies LOCK, retries, falls back to bypass.
module pll_lock_sequencer
  import pll_pkg::*;
#(
  parameter int RESET_CYCLES   = DEF_RESET_CYCLES,
  parameter int LOCK_STABLE    = DEF_LOCK_STABLE,
  parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int MAX_RETRIES    = DEF_MAX_RETRIES,
  parameter int BYPASS_ON_FAIL = DEF_BYPASS_ON_FAIL
) (
  input  logic               clock_in,
  input  logic               reset_n,
  input  logic               pll_lock,
  input  logic               relock_req,
  output logic               pll_resetb,
  output logic               pll_bypass,
  output logic               sys_rst_n,
  output logic [STATE_W-1:0] state,
  output logic [3:0]         retry_count,
  output logic [7:0]         lost_count,
  output logic               fail
);

  localparam int RST_W = $clog2(RESET_CYCLES + 1);
  localparam int STB_W = $clog2(LOCK_STABLE + 1);
  localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);

  // Counters compare against "last" values so the hit happens on the edge that
  // would make the count equal the parameter; that same edge changes state.
  localparam logic [RST_W-1:0] RST_LAST  = RST_W'(RESET_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);
  localparam logic             BYP       = (BYPASS_ON_FAIL != 0);

  pll_state_t       state_reg;
  logic [RST_W-1:0] rst_cnt_reg;
  logic [STB_W-1:0] stb_cnt_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic [3:0]       retry_count_reg;
  logic [7:0]       lost_count_reg;
  logic             pll_resetb_reg;
  logic             pll_bypass_reg;
  logic             sys_rst_n_reg;
  logic             fail_reg;

  logic lock_s;
  logic stb_hit;
  logic to_hit;
  logic to_reset;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (clock_in),
    .rst_n (reset_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  assign stb_hit = lock_s && (stb_cnt_reg == STB_LAST);
  assign to_hit  = (to_cnt_reg == TO_LAST);

  // Every path that re-enters RESET from another state; RESET itself ignores relock_req.
  always_comb begin
    to_reset = 1'b0;
    case (state_reg)
      ST_WAIT_LOCK: to_reset = relock_req || (!stb_hit && to_hit && (retry_count_reg != RETRY_MAX));
      ST_RUN:       to_reset = relock_req || !lock_s;
      ST_FAIL:      to_reset = relock_req;
      default:      to_reset = 1'b0;
    endcase
  end

  // Sequencer FSM with counters and registered outputs.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_RESET;
      rst_cnt_reg     <= '0;
      stb_cnt_reg     <= '0;
      to_cnt_reg      <= '0;
      retry_count_reg <= '0;
      lost_count_reg  <= '0;
      pll_resetb_reg  <= 1'b0;
      pll_bypass_reg  <= 1'b0;
      sys_rst_n_reg   <= 1'b0;
      fail_reg        <= 1'b0;
    end else if (to_reset) begin
      state_reg      <= ST_RESET;
      rst_cnt_reg    <= '0;
      stb_cnt_reg    <= '0;
      to_cnt_reg     <= '0;
      pll_resetb_reg <= 1'b0;
      pll_bypass_reg <= 1'b0;
      sys_rst_n_reg  <= 1'b0;
      fail_reg       <= 1'b0;
      // A relock request restarts the retry budget; otherwise this is a timeout retry.
      if (relock_req) begin
        retry_count_reg <= '0;
      end else if (state_reg == ST_WAIT_LOCK) begin
        retry_count_reg <= retry_count_reg + 4'd1;
      end
      if ((state_reg == ST_RUN) && !lock_s && (lost_count_reg != 8'hFF)) begin
        lost_count_reg <= lost_count_reg + 8'd1;
      end
    end else begin
      case (state_reg)
        ST_RESET: begin
          if (rst_cnt_reg == RST_LAST) begin
            state_reg      <= ST_WAIT_LOCK;
            rst_cnt_reg    <= '0;
            pll_resetb_reg <= 1'b1;
          end else begin
            rst_cnt_reg <= rst_cnt_reg + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (stb_hit) begin
            state_reg       <= ST_RUN;
            retry_count_reg <= '0;
            sys_rst_n_reg   <= 1'b1;
          end else if (to_hit) begin
            // Retry budget exhausted (the retry path is handled by to_reset).
            state_reg      <= ST_FAIL;
            fail_reg       <= 1'b1;
            pll_bypass_reg <= BYP;
            pll_resetb_reg <= BYP;
            sys_rst_n_reg  <= BYP;
          end else begin
            to_cnt_reg  <= to_cnt_reg + 1'b1;
            stb_cnt_reg <= lock_s ? stb_cnt_reg + 1'b1 : '0;
          end
        end
        default: begin
          // RUN and FAIL hold until to_reset fires.
        end
      endcase
    end
  end

  assign state       = state_reg;
  assign retry_count = retry_count_reg;
  assign lost_count  = lost_count_reg;
  assign pll_resetb  = pll_resetb_reg;
  assign pll_bypass  = pll_bypass_reg;
  assign sys_rst_n   = sys_rst_n_reg;
  assign fail        = fail_reg;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with small timing parameters.
module tb_pll_lock_sequencer;

  logic       clock_in = 1'b0;
  logic       reset_n;
  logic       pll_lock;
  logic       relock_req;
  logic       pll_resetb;
  logic       pll_bypass;
  logic       sys_rst_n;
  logic [2:0] state;
  logic [3:0] retry_count;
  logic [7:0] lost_count;
  logic       fail;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_FAIL  = 3'd3;

  pll_lock_sequencer #(
    .RESET_CYCLES   (4),
    .LOCK_STABLE    (8),
    .LOCK_TIMEOUT   (64),
    .MAX_RETRIES    (2),
    .BYPASS_ON_FAIL (1)
  ) dut (
    .clock_in    (clock_in),
    .reset_n     (reset_n),
    .pll_lock    (pll_lock),
    .relock_req  (relock_req),
    .pll_resetb  (pll_resetb),
    .pll_bypass  (pll_bypass),
    .sys_rst_n   (sys_rst_n),
    .state       (state),
    .retry_count (retry_count),
    .lost_count  (lost_count),
    .fail        (fail)
  );

  always #5 clock_in = ~clock_in;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end else begin
      $display("ok   %s: %0d", tag, actual);
    end
  endtask

  // Advance on falling edges until state matches, bounded by budget.
  task automatic wait_state(input logic [2:0] s, input int budget, input string tag, output int n);
    n = 0;
    while (state !== s && n < budget) begin
      @(negedge clock_in);
      n++;
    end
    check(tag, state, s);
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_state"},      state,       S_RESET);
    check({pfx, "_resetb"},     pll_resetb,  1'b0);
    check({pfx, "_bypass"},     pll_bypass,  1'b0);
    check({pfx, "_sys_rst_n"},  sys_rst_n,   1'b0);
    check({pfx, "_retry"},      retry_count, 4'd0);
    check({pfx, "_lost"},       lost_count,  8'd0);
    check({pfx, "_fail"},       fail,        1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int cnt;
    int lowcnt;
    reset_n    = 1'b0;
    pll_lock   = 1'b0;
    relock_req = 1'b0;
    repeat (2) @(negedge clock_in);
    check_reset_values("por");

    // 1: power-up, RESETB pulse of 4 cycles, lock qualification of 8+2 cycles
    reset_n = 1'b1;
    repeat (3) @(negedge clock_in);
    check("resetb_low_c3", pll_resetb, 1'b0);
    @(negedge clock_in);
    check("resetb_high_c4", pll_resetb, 1'b1);
    check("wait_at_c4", state, S_WAIT);
    repeat (6) @(negedge clock_in);
    pll_lock = 1'b1;
    repeat (9) @(negedge clock_in);
    check("still_wait_9", state, S_WAIT);
    @(negedge clock_in);
    check("run_at_10", state, S_RUN);
    check("run_sys_rst_n", sys_rst_n, 1'b1);
    check("run_retry", retry_count, 4'd0);

    // relock_req alone in RUN: back to RESET, lost_count untouched
    relock_req = 1'b1;
    pll_lock   = 1'b0;
    @(negedge clock_in);
    relock_req = 1'b0;
    check("relock_state", state, S_RESET);
    check("relock_sys_rst_n", sys_rst_n, 1'b0);
    check("relock_lost", lost_count, 8'd0);
    wait_state(S_WAIT, 20, "reach_wait", n);
    check("reset_len", n, 4);

    // 2: lock toggling with period 6 never qualifies; timeout after 64 cycles
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock_in);
      cnt++;
      if (state != S_WAIT) break;
      pll_lock = ((cnt / 3) % 2) != 0;
    end
    pll_lock = 1'b0;
    check("timeout_cycles", cnt, 64);
    check("timeout_state", state, S_RESET);
    check("timeout_retry", retry_count, 4'd1);
    lowcnt = 0;
    while (pll_resetb == 1'b0 && lowcnt < 20) begin
      lowcnt++;
      @(negedge clock_in);
    end
    check("retry_resetb_low", lowcnt, 4);

    // 3: no lock at all -> two more timeouts, then FAIL with bypass
    wait_state(S_FAIL, 400, "reach_fail", n);
    check("fail_flag", fail, 1'b1);
    check("fail_bypass", pll_bypass, 1'b1);
    check("fail_sys_rst_n", sys_rst_n, 1'b1);
    check("fail_resetb", pll_resetb, 1'b1);
    check("fail_retry", retry_count, 4'd2);
    pll_lock = 1'b1;
    repeat (20) @(negedge clock_in);
    check("fail_ignores_lock", state, S_FAIL);
    relock_req = 1'b1;
    @(negedge clock_in);
    relock_req = 1'b0;
    check("fail_relock_state", state, S_RESET);
    check("fail_relock_retry", retry_count, 4'd0);
    check("fail_relock_bypass", pll_bypass, 1'b0);
    check("fail_relock_flag", fail, 1'b0);
    wait_state(S_RUN, 40, "relock_to_run", n);
    check("relock_to_run_cycles", n, 12);

    // 5: lock loss and relock_req seen on the same edge -> one increment
    pll_lock = 1'b0;
    @(negedge clock_in);
    pll_lock = 1'b1;
    @(negedge clock_in);
    relock_req = 1'b1;
    @(negedge clock_in);
    relock_req = 1'b0;
    check("both_state", state, S_RESET);
    check("both_lost", lost_count, 8'd1);
    check("both_retry", retry_count, 4'd0);
    wait_state(S_RUN, 40, "both_rerun", n);
    relock_req = 1'b1;
    @(negedge clock_in);
    relock_req = 1'b0;
    check("relock_only_lost", lost_count, 8'd1);

    // 4: one-cycle lock drop in RUN, then repeated until lost_count saturates
    wait_state(S_RUN, 40, "loss_run", n);
    pll_lock = 1'b0;
    @(negedge clock_in);
    pll_lock = 1'b1;
    @(negedge clock_in);
    check("loss_still_run", state, S_RUN);
    @(negedge clock_in);
    check("loss_state", state, S_RESET);
    check("loss_sys_rst_n", sys_rst_n, 1'b0);
    check("loss_lost", lost_count, 8'd2);
    for (int k = 3; k <= 300; k++) begin
      wait_state(S_RUN, 40, "loop_run", n);
      pll_lock = 1'b0;
      @(negedge clock_in);
      pll_lock = 1'b1;
      wait_state(S_RESET, 10, "loop_reset", n);
      if (k == 255) check("lost_at_255", lost_count, 8'd255);
    end
    check("lost_saturated", lost_count, 8'd255);

    // 6: asynchronous reset in the middle of WAIT_LOCK
    pll_lock = 1'b0;
    wait_state(S_WAIT, 20, "pre_arst_wait", n);
    repeat (10) @(negedge clock_in);
    check("pre_arst_resetb", pll_resetb, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_values("arst");
    @(negedge clock_in);
    reset_n  = 1'b1;
    pll_lock = 1'b1;
    repeat (3) @(negedge clock_in);
    check("restart_resetb_c3", pll_resetb, 1'b0);
    @(negedge clock_in);
    check("restart_resetb_c4", pll_resetb, 1'b1);
    wait_state(S_RUN, 40, "restart_run", n);
    check("restart_sys_rst_n", sys_rst_n, 1'b1);
    #2 reset_n = 1'b0;
    #1 check("arst_run_sys_rst_n", sys_rst_n, 1'b0);
    check("arst_run_state", state, S_RESET);
    @(negedge clock_in);
    reset_n = 1'b1;
    @(negedge clock_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
